frag_ifetch: RTL

Instruction fetch unit for the fragment core: the producer side of the control unit's instruction interface (`instr`/`valid`/`stall`). It holds the fragment program counter, issues pipelined word reads to instruction memory, buffers returned words, and presents them in order to the control unit. It honours back-pressure from the control unit and redirects on flush.

---
 rtl/frag_fetch_pkg.sv | 10 +
 rtl/fetch_ret_buf.sv | 46 ++++
 rtl/frag_ifetch.sv | 81 ++++++++
 3 files changed

// File: rtl/frag_fetch_pkg.sv
// frag_fetch_pkg: shared types and constants for the fragment instruction fetch unit.
package frag_fetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
  localparam int unsigned PC_STEP   = 4;
  localparam int unsigned DEF_DEPTH = 4;
endpackage

// File: rtl/fetch_ret_buf.sv
// fetch_ret_buf: circular FIFO holding returned instruction words until the control unit takes them.
module fetch_ret_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_d  = clear_i ? '0 : wr_q + AW'(push_i);
    rd_d  = clear_i ? '0 : rd_q + AW'(pop_i);
    cnt_d = clear_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem[wr_q] <= data_i;
  end

  assign head_o  = mem[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/frag_ifetch.sv
// frag_ifetch: fetches words from instruction memory at the fragment PC and delivers them in order
// to the control unit, honouring stall back-pressure and flush redirects.
module frag_ifetch
  import frag_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] start_pc_i,
  input  logic             halt_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] instr_o,
  output logic             valid_o,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic [WIDTH-1:0] imem_addr_o,
  output logic             imem_req_o,
  input  logic             imem_ready_i,
  input  logic [WIDTH-1:0] imem_data_i,
  input  logic             imem_valid_i
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, head;
  logic [CW-1:0]    inflight_q, inflight_d, discard_q, discard_d, buf_count;
  logic             flush, accept, drop, push, pop;

  assign flush  = flush_i && state_q != IDLE;
  // Credit check keeps outstanding plus buffered words within the buffer size.
  assign imem_req_o = state_q == RUN && (CW+1)'(inflight_q) + (CW+1)'(buf_count) < (CW+1)'(DEPTH);
  assign accept = imem_req_o && imem_ready_i;
  assign drop   = imem_valid_i && discard_q != '0;
  assign push   = imem_valid_i && !drop && !flush;
  assign pop    = valid_o && !stall_i && !flush;

  always_comb begin
    inflight_d = inflight_q + CW'(accept) - CW'(imem_valid_i);
    discard_d  = flush ? inflight_d : discard_q - CW'(drop);
    pc_d       = flush ? redirect_pc_i :
                 (state_q == IDLE && start_i) ? start_pc_i :
                 accept ? pc_q + WIDTH'(PC_STEP) : pc_q;
    state_d    = (state_q == IDLE && start_i) ? RUN :
                 (state_q == RUN && halt_i) ? DRAIN :
                 (state_q == DRAIN && inflight_q == '0 && buf_count == '0) ? IDLE : state_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_ret_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush),
    .data_i  (imem_data_i),
    .head_o  (head),
    .count_o (buf_count)
  );

  assign valid_o     = buf_count != '0;
  assign instr_o     = valid_o ? head : '0;
  assign busy_o      = state_q != IDLE;
  assign imem_addr_o = pc_q;
endmodule
